string_assembler: RTL
=====================

Name: string_assembler

Overview:
- Upstream stage that feeds the string length finder.
- Accepts a byte-serial character stream through a valid/ready handshake and packs it into a 64-bit, 8-character, null-padded string.
- Presents each finished string with a valid/ready handshake; character 0 sits in bits [7:0].
- A string terminates on a null byte (8'h00) or after the 8th character.

Parameters:
- TIMEOUT_CYCLES, 16, idle cycles before a partial string is flushed. Used only with STRING_ASM_TIMEOUT_EN; legal range 1..255.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- char_in  input  8  incoming character byte
- char_valid  input  1  char_in valid this cycle
- char_ready  output  1  block can accept a character this cycle
- string_out  output  64  assembled string; char k in bits [8k+7:8k]
- string_valid  output  1  string_out complete and stable
- string_ready  input  1  downstream consumes string_out this cycle

Behaviour:
- State register: COLLECT or HOLD. Internal 3-bit write index idx. Internal 64-bit buffer buf drives string_out directly.
- Reset (asynchronous, active-high, any time, including mid-string or mid-HOLD):
  - state=COLLECT, idx=0, buf=64'h0
  - string_valid=0, char_ready=1
  - Partially collected data is discarded.
- char_ready = (state==COLLECT). string_valid = (state==HOLD). Both are registered-state decodes with no combinational path from inputs.
- A character is accepted when char_valid & char_ready at a rising edge.
- COLLECT, accepted non-null byte:
  - buf[8*idx +: 8] <= char_in.
  - If idx==7: go to HOLD; idx is don't-care.
  - Otherwise idx <= idx+1.
- COLLECT, accepted null byte:
  - Nothing is written; the buffer slot is already 0.
  - Go to HOLD.
  - A null at idx==0 yields string_out=64'h0.
- Latency: string_valid is high the cycle after the terminating byte is accepted.
- HOLD:
  - string_out held constant; char_ready=0. Upstream must hold its byte.
  - On string_valid & string_ready: buf<=0, idx<=0, go to COLLECT.
  - char_ready rises the following cycle, so there is one bubble cycle between strings.
- Unused bytes above the terminator are always 8'h00. The downstream length finder therefore sees exactly one of:
  - a null in byte position = length, or
  - no null at all (length 8).
- char_valid is ignored in HOLD. string_ready is ignored in COLLECT.
- No overflow is possible: the 8th character forces HOLD.

Optional Feature:
- Macro: STRING_ASM_TIMEOUT_EN.
- Defined:
  - An 8-bit idle counter resets to 0 on every accepted character, on reset, and on entering COLLECT.
  - The counter increments each COLLECT cycle with no accepted character while idx!=0.
  - When it reaches TIMEOUT_CYCLES, go to HOLD with the current buf, which is already null-padded.
  - Timeout has no effect when idx==0; empty strings are never emitted by timeout.
  - If the timeout and an accepted character coincide, the character wins and the counter clears.
- Undefined:
  - No counter exists.
  - COLLECT waits indefinitely for a null or the 8th character.

Test Plan:
- Send 'H','I',8'h00 back-to-back with string_ready=1:
  - string_out=64'h0000_0000_0000_4948.
  - string_valid high for 1 cycle, one cycle after the null is accepted.
  - char_ready low only during that cycle.
- Send 'A'..'H' (8'h41..8'h48), no null:
  - HOLD is entered after the 8th byte.
  - string_out=64'h4847_4645_4443_4241.
  - A 9th byte offered with char_valid=1 is not accepted until after the handshake.
- Send 8'h00 first: string_out=64'h0, string_valid=1.
- Send 'X',8'h00 with string_ready held 0 for 5 cycles:
  - string_out stays 64'h58 and string_valid stays 1.
  - char_ready stays 0.
  - Release: next string assembles from a cleared buffer, with no stale 'X' in byte 0.
- Send 'A','B', then assert reset for 1 cycle, then 'C',8'h00:
  - Outputs clear asynchronously during reset.
  - Next string_out=64'h43.
- With STRING_ASM_TIMEOUT_EN and TIMEOUT_CYCLES=16:
  - Send 'Q' then idle: string_valid rises after 16 idle cycles with string_out=64'h51.
  - Idle with idx==0 for 100 cycles: string_valid stays 0.

Source files
------------

// File: rtl/string_assembler.sv
// Packs a byte-serial character stream into an 8-char, null-padded string.
// Optional idle flush of partial strings with STRING_ASM_TIMEOUT_EN.
module string_assembler #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [63:0] string_out,
  output logic        string_valid,
  input  logic        string_ready
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] HOLD    = 1'b1;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..255");
  end

  logic [0:0]  state;
  logic [2:0]  idx;
  logic [63:0] data_buf;
  logic        accept;

  assign char_ready   = (state == COLLECT);
  assign string_valid = (state == HOLD);
  assign string_out   = data_buf;
  assign accept       = char_valid & char_ready;

`ifdef STRING_ASM_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] idle_cnt;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= COLLECT;
      idx      <= 3'd0;
      data_buf <= 64'h0;
`ifdef STRING_ASM_TIMEOUT_EN
      idle_cnt <= 8'd0;
`endif
    end else begin
      unique case (state)
        COLLECT: begin
          if (accept) begin
`ifdef STRING_ASM_TIMEOUT_EN
            idle_cnt <= 8'd0;
`endif
            if (char_in != 8'h00) begin
              data_buf[{idx, 3'b000} +: 8] <= char_in;
              idx <= idx + 3'd1;
              if (idx == 3'd7)
                state <= HOLD;
            end else begin
              // slot is already zero from the clear on handshake
              state <= HOLD;
            end
          end
`ifdef STRING_ASM_TIMEOUT_EN
          else if (idx != 3'd0) begin
            if (idle_cnt == TMO_LAST)
              state <= HOLD;
            else
              idle_cnt <= idle_cnt + 8'd1;
          end
`endif
        end
        HOLD: begin
          if (string_ready) begin
            data_buf <= 64'h0;
            idx      <= 3'd0;
            state    <= COLLECT;
`ifdef STRING_ASM_TIMEOUT_EN
            idle_cnt <= 8'd0;
`endif
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
